// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path: store size encodings,
// controller state type and address helpers.
package mem_pkg;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WAIT  = 2'b10,
        S_WRITE = 2'b11
    } rmw_state_e;

    // Encoding 11 is reserved and handled exactly like a word store.
    function automatic logic is_word_type(input logic [1:0] st_type);
        return st_type[1];
    endfunction

    // Sized for the widest address in use; callers cast to their own width.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sub-word stores ahead of the store merge stage.
// Word stores skip the read; byte/half stores read, merge externally, then write back.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request; misaligned half is flagged and dropped
// S_READ  | MemRE issued for the containing word, latency counter loaded
// S_WAIT  | counting down read latency, read word captured at zero
// S_WRITE | MemWE issued with the merged (or bypassed) word, Done pulses
module store_rmw_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [1:0]            ReqType,
    input  logic [31:0]           ReqData,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRE,
    input  logic [31:0]           MemRData,
    output logic                  MemWE,
    output logic [31:0]           MemWData,
    output logic [1:0]            MergeA,
    output logic [1:0]            MergeType,
    output logic [31:0]           MergeRD,
    output logic [31:0]           MergeWD,
    input  logic [31:0]           MergeOut,
    output logic                  Done,
    output logic                  Err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    rmw_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            a_q, a_d;
    logic [1:0]            type_q, type_d;
    logic [31:0]           wd_q, wd_d;
    logic [31:0]           rd_q, rd_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            a_q     <= '0;
            type_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            type_q  <= type_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        a_d     = a_q;
        type_d  = type_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    addr_d = ADDR_WIDTH'(word_align(64'(ReqAddr)));
                    a_d    = ReqAddr[1:0];
                    type_d = ReqType;
                    wd_d   = ReqData;
                    if (is_word_type(ReqType)) begin
                        state_d = S_WRITE;
                    end else if (ReqType == ST_HALF && ReqAddr[0]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rd_d    = MemRData;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ReqReady  = (state_q == S_IDLE);
    assign MemRE     = (state_q == S_READ);
    assign MemWE     = (state_q == S_WRITE);
    assign MemAddr   = addr_q;
    assign MergeA    = a_q;
    assign MergeType = type_q;
    assign MergeRD   = rd_q;
    assign MergeWD   = wd_q;
    // Word stores never read, so the merge stage result is ignored for them.
    assign MemWData  = is_word_type(type_q) ? wd_q : MergeOut;
    assign Done      = (state_q == S_WRITE) | err_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (read latency 1 and 3), each with a
// behavioural data memory and merge stage, checked against a write scoreboard.
module tb_store_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_type = '0;
    logic [31:0] req_data = '0;
    logic        valid1 = 1'b0, valid3 = 1'b0;

    logic        ready1, re1, we1, done1, err1;
    logic [31:0] maddr1, wdata1, mrd1, mwd1, rdata1, mout1;
    logic [1:0]  ma1, mt1;
    logic        ready3, re3, we3, done3, err3;
    logic [31:0] maddr3, wdata3, mrd3, mwd3, rdata3, mout3;
    logic [1:0]  ma3, mt3;

    logic [31:0] mem1 [logic [29:0]];
    logic [31:0] mem3 [logic [29:0]];
    logic [31:0] pipe3 [3];
    logic [31:0] exp_q [$];

    int tests_run = 0;
    int tests_failed = 0;

    logic        sel3 = 1'b0;
    logic        o_ready, o_re, o_we, o_done, o_err;
    logic [31:0] o_maddr, o_wdata;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.ADDR_WIDTH(32), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ReqValid(valid1), .ReqReady(ready1),
        .ReqAddr(req_addr), .ReqType(req_type), .ReqData(req_data),
        .MemAddr(maddr1), .MemRE(re1), .MemRData(rdata1), .MemWE(we1),
        .MemWData(wdata1), .MergeA(ma1), .MergeType(mt1), .MergeRD(mrd1),
        .MergeWD(mwd1), .MergeOut(mout1), .Done(done1), .Err(err1)
    );

    store_rmw_ctrl #(.ADDR_WIDTH(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ReqValid(valid3), .ReqReady(ready3),
        .ReqAddr(req_addr), .ReqType(req_type), .ReqData(req_data),
        .MemAddr(maddr3), .MemRE(re3), .MemRData(rdata3), .MemWE(we3),
        .MemWData(wdata3), .MergeA(ma3), .MergeType(mt3), .MergeRD(mrd3),
        .MergeWD(mwd3), .MergeOut(mout3), .Done(done3), .Err(err3)
    );

    function automatic logic [31:0] merge_f(input logic [1:0] a, input logic [1:0] t,
                                            input logic [31:0] rd, input logic [31:0] wd);
        logic [31:0] r;
        r = rd;
        case (t)
            2'b00:   r[int'(a) * 8 +: 8] = wd[7:0];
            2'b01:   r[int'(a[1]) * 16 +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign mout1 = merge_f(ma1, mt1, mrd1, mwd1);
    assign mout3 = merge_f(ma3, mt3, mrd3, mwd3);

    // Memories drive zero except exactly RD_LAT cycles after a read.
    always @(posedge clk) begin
        rdata1 <= re1 ? mem1[maddr1[31:2]] : 32'h0;
        pipe3[0] <= re3 ? mem3[maddr3[31:2]] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (we1) mem1[maddr1[31:2]] = wdata1;
        if (we3) mem3[maddr3[31:2]] = wdata3;
    end
    assign rdata3 = pipe3[2];

    always_comb begin
        o_ready = sel3 ? ready3 : ready1;
        o_re    = sel3 ? re3    : re1;
        o_we    = sel3 ? we3    : we1;
        o_done  = sel3 ? done3  : done1;
        o_err   = sel3 ? err3   : err1;
        o_maddr = sel3 ? maddr3 : maddr1;
        o_wdata = sel3 ? wdata3 : wdata1;
    end

    task automatic run_store(input bit use3, input logic [31:0] addr, input logic [1:0] typ,
                             input logic [31:0] data, input logic [31:0] exp_wd,
                             input int exp_re, input int exp_we, input string name);
        int re_c, we_c, ovl, unstable;
        logic [31:0] wd_seen, exp_v;
        logic done_seen;
        re_c = -1; we_c = -1; ovl = 0; unstable = 0; wd_seen = '0; done_seen = 1'b0;
        sel3 = use3;
        exp_q.push_back(exp_wd);
        @(posedge clk); #1;
        req_addr = addr; req_type = typ; req_data = data;
        if (use3) valid3 = 1'b1; else valid1 = 1'b1;
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++; $display("FAIL %s ready_idle: got %b want 1", name, o_ready);
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            valid1 = 1'b0; valid3 = 1'b0;
            if (o_re && o_we) ovl++;
            if (o_maddr !== {addr[31:2], 2'b00}) unstable++;
            if (o_re && re_c < 0) re_c = c;
            if (o_we) begin
                we_c = c; wd_seen = o_wdata; done_seen = o_done;
                break;
            end
        end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        tests_run++;
        if (re_c != exp_re) begin
            tests_failed++; $display("FAIL %s re_cycle: got %0d want %0d", name, re_c, exp_re);
        end
        tests_run++;
        if (we_c != exp_we) begin
            tests_failed++; $display("FAIL %s we_cycle: got %0d want %0d", name, we_c, exp_we);
        end
        tests_run++;
        if (wd_seen !== exp_v) begin
            tests_failed++; $display("FAIL %s wdata: got %h want %h", name, wd_seen, exp_v);
        end
        tests_run++;
        if (done_seen !== 1'b1 || ovl != 0 || unstable != 0) begin
            tests_failed++;
            $display("FAIL %s done/overlap/addr: got done=%b ovl=%0d unstable=%0d want 1/0/0",
                     name, done_seen, ovl, unstable);
        end
        @(posedge clk); #1;
        tests_run++;
        if (o_ready !== 1'b1 || o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after_write: got ready=%b done=%b want 1/0", name, o_ready, o_done);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests_run++;
        if ({re1, we1, done1, err1, ma1, mt1, maddr1, mrd1, mwd1} !== '0) begin
            tests_failed++;
            $display("FAIL %s dut1_outputs: got re=%b we=%b done=%b err=%b addr=%h rd=%h wd=%h want all 0",
                     name, re1, we1, done1, err1, maddr1, mrd1, mwd1);
        end
        tests_run++;
        if ({re3, we3, done3, err3, ma3, mt3, maddr3, mrd3, mwd3} !== '0) begin
            tests_failed++;
            $display("FAIL %s dut3_outputs: got re=%b we=%b done=%b err=%b addr=%h want all 0",
                     name, re3, we3, done3, err3, maddr3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b%b want 11", ready1, ready3);
        end
    endtask

    task automatic test_byte();
        mem1[30'h40] = 32'hAABBCCDD;
        run_store(1'b0, 32'h101, 2'b00, 32'h11, 32'hAABB11DD, 1, 3, "byte");
    endtask

    task automatic test_half();
        mem1[30'h80] = 32'h12345678;
        run_store(1'b0, 32'h202, 2'b01, 32'hBEEF, 32'hBEEF5678, 1, 3, "half_hi");
        mem1[30'h80] = 32'h12345678;
        run_store(1'b0, 32'h200, 2'b01, 32'hBEEF, 32'h1234BEEF, 1, 3, "half_lo");
    endtask

    task automatic test_word();
        run_store(1'b0, 32'h304, 2'b10, 32'hDEADBEEF, 32'hDEADBEEF, -1, 1, "word");
        run_store(1'b0, 32'h30B, 2'b11, 32'h0BADF00D, 32'h0BADF00D, -1, 1, "word_t11");
        tests_run++;
        if (mem1[30'hC1] !== 32'hDEADBEEF || mem1[30'hC2] !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL word_mem: got %h %h want deadbeef 0badf00d", mem1[30'hC1], mem1[30'hC2]);
        end
    endtask

    task automatic test_misaligned();
        int acc;
        sel3 = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        req_addr = 32'h401; req_type = 2'b01; req_data = 32'h5555;
        valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        tests_run++;
        if ({err1, done1, re1, we1, ready1} !== 5'b11001) begin
            tests_failed++;
            $display("FAIL misaligned_pulse: got err=%b done=%b re=%b we=%b ready=%b want 1/1/0/0/1",
                     err1, done1, re1, we1, ready1);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            acc += int'(re1) + int'(we1) + int'(err1) + int'(done1);
        end
        tests_run++;
        if (acc != 0) begin
            tests_failed++; $display("FAIL misaligned_quiet: got %0d active strobes want 0", acc);
        end
    endtask

    task automatic test_rd_lat3();
        mem3[30'h40] = 32'h01020304;
        run_store(1'b1, 32'h103, 2'b00, 32'h5A, 32'h5A020304, 1, 5, "rdlat3_byte");
    endtask

    task automatic test_back_to_back();
        int acc_c [$];
        int we_c [$];
        logic prev_ready;
        logic [31:0] exp_v;
        sel3 = 1'b1;
        mem3[30'h40] = 32'h01020304;
        exp_q.push_back(32'h5A020304);
        exp_q.push_back(32'h5A020304);
        @(posedge clk); #1;
        req_addr = 32'h103; req_type = 2'b00; req_data = 32'h5A;
        valid3 = 1'b1;
        prev_ready = ready3;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (prev_ready && valid3) acc_c.push_back(c);
            if (acc_c.size() >= 2) valid3 = 1'b0;
            if (we3) begin
                we_c.push_back(c);
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                tests_run++;
                if (wdata3 !== exp_v) begin
                    tests_failed++; $display("FAIL b2b_wdata: got %h want %h", wdata3, exp_v);
                end
            end
            prev_ready = ready3;
        end
        valid3 = 1'b0;
        tests_run++;
        if (acc_c.size() != 2 || acc_c[0] != 1 || acc_c[1] != 7) begin
            tests_failed++;
            $display("FAIL b2b_accepts: got %0d accepts (first %0d second %0d) want 2 at 1,7",
                     acc_c.size(), (acc_c.size() > 0) ? acc_c[0] : -1, (acc_c.size() > 1) ? acc_c[1] : -1);
        end
        tests_run++;
        if (we_c.size() != 2 || we_c[0] != 5 || we_c[1] != 11) begin
            tests_failed++;
            $display("FAIL b2b_writes: got %0d writes (first %0d second %0d) want 2 at 5,11",
                     we_c.size(), (we_c.size() > 0) ? we_c[0] : -1, (we_c.size() > 1) ? we_c[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int we_cnt;
        sel3 = 1'b0;
        we_cnt = 0;
        mem1[30'h40] = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_addr = 32'h100; req_type = 2'b00; req_data = 32'h77;
        valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("reset_mid");
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (we1) we_cnt++;
            if (c == 0) begin
                tests_run++;
                if (ready1 !== 1'b1) begin
                    tests_failed++; $display("FAIL reset_mid_ready: got %b want 1", ready1);
                end
            end
        end
        tests_run++;
        if (we_cnt != 0 || mem1[30'h40] !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL reset_mid_nowrite: got %0d writes mem=%h want 0 aabbccdd", we_cnt, mem1[30'h40]);
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_misaligned();
        test_rd_lat3();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
